// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported I/D memory between fetch (IF) and data (MEM) stages
//   i_clock/i_reset        : clock, async active-high reset
//   i_if_*  / o_if_*       : fetch request (held until o_if_valid) and returned instruction
//   i_dm_*  / o_dm_*       : data request (held until o_dm_done) and returned load data
//   o_mem_* / i_mem_*      : variable-latency memory handshake (o_mem_req held until i_mem_ack)
//   o_stall_if/o_stall_mem : pipeline freeze for stages still waiting
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_done,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_stall_if,
  output logic              o_stall_mem
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;
  state_t            r_state, w_next;
  logic [SW-1:0]     r_starve;
  logic              r_owner_dm, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic              w_grant_dm, w_grant_if, w_busy;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  // Data wins unless fetch has already waited out STARVE_MAX data grants.
  always_comb begin
    w_busy     = r_state == BUSY_IF || r_state == BUSY_DM;
    w_grant_dm = r_state == IDLE && i_dm_req && !(i_if_req && r_starve == SMAX);
    w_grant_if = r_state == IDLE && i_if_req && !w_grant_dm;
    w_next     = w_grant_dm ? BUSY_DM :
                 w_grant_if ? BUSY_IF :
                 (w_busy && i_mem_ack) ? RESP :
                 r_state == RESP ? IDLE : r_state;
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_starve    <= '0;
      r_owner_dm  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      if (w_grant_dm || w_grant_if) begin
        r_owner_dm  <= w_grant_dm;
        r_mem_we    <= w_grant_dm && i_dm_we;
        r_mem_addr  <= w_grant_dm ? i_dm_addr : i_if_addr;
        r_mem_wdata <= w_grant_dm ? i_dm_wdata : r_mem_wdata;
      end
      if (w_grant_dm && i_if_req && r_starve != SMAX) r_starve <= r_starve + 1'b1;
      else if (w_grant_if) r_starve <= '0;
      if (r_state == BUSY_IF && i_mem_ack) r_if_rdata <= i_mem_rdata;
      if (r_state == BUSY_DM && i_mem_ack && !r_mem_we) r_dm_rdata <= i_mem_rdata;
    end
  // Write enable is only presented while a request is outstanding.
  assign o_mem_req   = w_busy;
  assign o_mem_we    = r_mem_we && w_busy;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_if_valid  = r_state == RESP && !r_owner_dm;
  assign o_dm_done   = r_state == RESP && r_owner_dm;
  assign o_stall_if  = i_if_req && !o_if_valid;
  assign o_stall_mem = i_dm_req && !o_dm_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and a randomized transaction-level check
module tb_mem_port_arbiter;
  localparam int SM = 3;
  logic        i_clock = 1'b0, i_reset = 1'b1;
  logic        i_if_req = 1'b0, i_dm_req = 1'b0, i_dm_we = 1'b0, i_mem_ack = 1'b0;
  logic [31:0] i_if_addr = '0, i_dm_addr = '0, i_dm_wdata = '0, i_mem_rdata = '0;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_valid, o_dm_done, o_mem_req, o_mem_we, o_stall_if, o_stall_mem;
  int tests = 0, fails = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .o_dm_rdata(o_dm_rdata), .o_dm_done(o_dm_done),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem));
  always #5 i_clock = ~i_clock;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic [5:0]  ef;
    logic [31:0] eif, edm;
  } vec_t;
  function automatic vec_t v(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                             logic [31:0] dd, logic ak, logic [31:0] rd, logic [5:0] ef,
                             logic [31:0] eif, logic [31:0] edm);
    vec_t t;
    t.if_req = ir; t.if_addr = ia; t.dm_req = dr; t.dm_we = dw; t.dm_addr = da; t.dm_wdata = dd;
    t.ack = ak; t.rdata = rd; t.ef = ef; t.eif = eif; t.edm = edm;
    return t;
  endfunction
  logic [31:0] mem_m [logic [31:0]];
  function automatic logic [31:0] rd_mem(logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : ~a;
  endfunction
  vec_t tv [15];
  int lat_tab [6] = '{1, 5, 12, 1, 1, 2};
  initial begin
    logic [7:0]  order;
    int          n, m, lat, starve, L;
    logic        prev, use_if, own_dm, t_we, acked;
    logic [31:0] t_addr, t_wdata, t_rdata, e_if, e_dm;
    // ef = {mem_req, mem_we, if_valid, dm_done, stall_if, stall_mem}
    tv[0]  = v(1, 32'h10, 0, 0, 0, 0, 0, 0, 6'b000010, 0, 0);
    tv[1]  = v(1, 32'h10, 0, 0, 0, 0, 0, 0, 6'b100010, 0, 0);
    tv[2]  = v(1, 32'h10, 0, 0, 0, 0, 1, 32'h00500293, 6'b100010, 0, 0);
    tv[3]  = v(1, 32'h10, 0, 0, 0, 0, 0, 0, 6'b001000, 32'h00500293, 0);
    tv[4]  = v(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h00500293, 0);
    tv[5]  = v(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 6'b000001, 32'h00500293, 0);
    tv[6]  = v(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 6'b110001, 32'h00500293, 0);
    tv[7]  = v(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 6'b110001, 32'h00500293, 0);
    tv[8]  = v(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 1, 32'h12345678, 6'b110001, 32'h00500293, 0);
    tv[9]  = v(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 6'b000100, 32'h00500293, 0);
    tv[10] = v(0, 0, 1, 0, 32'h100, 0, 0, 0, 6'b000001, 32'h00500293, 0);
    tv[11] = v(0, 0, 1, 0, 32'h100, 0, 0, 0, 6'b100001, 32'h00500293, 0);
    tv[12] = v(0, 0, 1, 0, 32'h100, 0, 1, 32'hDEADBEEF, 6'b100001, 32'h00500293, 0);
    tv[13] = v(0, 0, 1, 0, 32'h100, 0, 0, 0, 6'b000100, 32'h00500293, 32'hDEADBEEF);
    tv[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h00500293, 32'hDEADBEEF);
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b0;
    #3 chk("reset_state", {o_mem_req, o_mem_we, o_if_valid, o_dm_done, o_stall_if, o_stall_mem,
                           o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata}, '0);
    // directed single fetch, store, load
    for (int i = 0; i < 15; i++) begin
      @(posedge i_clock); #1;
      i_if_req = tv[i].if_req; i_if_addr = tv[i].if_addr; i_dm_req = tv[i].dm_req; i_dm_we = tv[i].dm_we;
      i_dm_addr = tv[i].dm_addr; i_dm_wdata = tv[i].dm_wdata; i_mem_ack = tv[i].ack; i_mem_rdata = tv[i].rdata;
      #3;
      chk($sformatf("vec%0d_flags", i),
          {o_mem_req, o_mem_we, o_if_valid, o_dm_done, o_stall_if, o_stall_mem}, tv[i].ef);
      chk($sformatf("vec%0d_rdata", i), {o_if_rdata, o_dm_rdata}, {tv[i].eif, tv[i].edm});
      if (tv[i].ef[5]) chk($sformatf("vec%0d_addr", i), o_mem_addr, tv[i].dm_req ? tv[i].dm_addr : tv[i].if_addr);
    end
    // contention: both held, ack always present -> DM DM DM IF repeating
    @(posedge i_clock); #1;
    i_if_req = 1; i_if_addr = 32'h40; i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h80;
    i_mem_ack = 1; i_mem_rdata = 32'h1234;
    order = '0; n = 0; prev = 1'b0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      #3;
      if (o_mem_req && !prev) begin
        order = {order[6:0], o_mem_addr == 32'h80};
        n++;
      end
      prev = o_mem_req;
      @(posedge i_clock); #1;
    end
    chk("contention_count", n, 8);
    chk("contention_order", order, 8'b11101110);
    i_if_req = 0; i_dm_req = 0;
    repeat (3) @(posedge i_clock);
    #1 i_mem_ack = 0;
    // reset mid-transaction, then a stale ack
    @(posedge i_clock); #1 i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h20;
    @(posedge i_clock); #1 chk("rst_busy", o_mem_req, 1);
    #1 i_reset = 1; i_dm_req = 0;
    #1 chk("rst_async", {o_mem_req, o_mem_we, o_mem_addr}, '0);
    @(posedge i_clock); #1 i_reset = 0;
    @(posedge i_clock); #1 i_mem_ack = 1; i_mem_rdata = 32'hBAD0BAD0;
    #3 chk("rst_stale_ack", {o_dm_done, o_mem_req}, '0);
    @(posedge i_clock); #1 i_mem_ack = 0;
    #3 chk("rst_stale_after", {o_dm_done, o_dm_rdata, o_mem_req}, '0);
    // variable latency stores, then zero-gap held fetches
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clock); #1;
      use_if = k >= 3; L = lat_tab[k];
      i_if_req = use_if; i_if_addr = 32'h300 + 32'(k) * 4;
      i_dm_req = !use_if; i_dm_we = 1; i_dm_addr = 32'h200 + 32'(k) * 4; i_dm_wdata = 32'hA0000000 + 32'(k);
      #3 chk($sformatf("vl%0d_idle", k), {o_mem_req, o_if_valid, o_dm_done}, '0);
      for (int j = 1; j <= L; j++) begin
        @(posedge i_clock); #1 i_mem_ack = j == L; i_mem_rdata = 32'hC0DE0000 + 32'(k);
        #3 chk($sformatf("vl%0d_hold%0d", k, j), {o_mem_req, o_mem_we, o_mem_addr, o_if_valid, o_dm_done},
               {1'b1, !use_if, use_if ? i_if_addr : i_dm_addr, 2'b00});
        if (!use_if) chk($sformatf("vl%0d_wdata%0d", k, j), o_mem_wdata, i_dm_wdata);
      end
      @(posedge i_clock); #1 i_mem_ack = 0;
      #3 chk($sformatf("vl%0d_pulse", k), {o_mem_req, o_if_valid, o_dm_done}, {1'b0, use_if, !use_if});
      if (use_if) chk($sformatf("vl%0d_ifdata", k), o_if_rdata, 32'hC0DE0000 + 32'(k));
    end
    @(posedge i_clock); #1;
    chk("vl_no_dup", {o_mem_req, o_if_valid}, '0);
    i_if_req = 0; i_dm_req = 0;
    // randomized traffic against a transaction-level model
    #1 i_reset = 1; #1 i_reset = 0;
    m = 0; lat = 0; starve = 0; acked = 0; own_dm = 0; t_we = 0;
    t_addr = 0; t_wdata = 0; t_rdata = 0; e_if = 0; e_dm = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clock);
      chk("r_stall", {o_stall_if, o_stall_mem}, {i_if_req & ~o_if_valid, i_dm_req & ~o_dm_done});
      if (m == 0) begin
        chk("r_grant", {o_mem_req, o_if_valid, o_dm_done}, {i_if_req | i_dm_req, 2'b00});
        if (i_if_req || i_dm_req) begin
          own_dm = i_dm_req && !(i_if_req && starve == SM);
          if (own_dm && i_if_req) starve = starve < SM ? starve + 1 : SM;
          else if (!own_dm) starve = 0;
          t_we = own_dm && i_dm_we; t_addr = own_dm ? i_dm_addr : i_if_addr; t_wdata = i_dm_wdata;
          chk("r_owner", {o_mem_we, o_mem_addr}, {t_we, t_addr});
          if (t_we) chk("r_wdata", o_mem_wdata, t_wdata);
          m = 1; lat = $urandom_range(0, 3);
        end
      end else if (m == 1) begin
        if (acked) begin
          chk("r_pulse", {o_mem_req, o_if_valid, o_dm_done}, {1'b0, !own_dm, own_dm});
          if (!own_dm) e_if = t_rdata;
          else if (!t_we) e_dm = t_rdata;
          m = 2;
        end else begin
          chk("r_busy", {o_mem_req, o_mem_we, o_mem_addr, o_if_valid, o_dm_done}, {1'b1, t_we, t_addr, 2'b00});
          if (t_we) chk("r_busy_wdata", o_mem_wdata, t_wdata);
        end
      end else begin
        chk("r_resp_gap", {o_mem_req, o_if_valid, o_dm_done}, '0);
        m = 0;
      end
      chk("r_rdata", {o_if_rdata, o_dm_rdata}, {e_if, e_dm});
      acked = 0; i_mem_ack = 0; i_mem_rdata = $urandom;
      if (m == 1) begin
        if (lat == 0) begin
          i_mem_ack = 1; acked = 1;
          if (t_we) mem_m[t_addr] = t_wdata;
          else i_mem_rdata = rd_mem(t_addr);
          t_rdata = i_mem_rdata;
        end else lat--;
      end else if ($urandom_range(0, 3) == 0) i_mem_ack = 1;
      if (o_if_valid || !i_if_req) begin
        i_if_req = $urandom_range(0, 3) != 0;
        i_if_addr = 32'($urandom_range(0, 7)) << 2;
      end
      if (o_dm_done || !i_dm_req) begin
        i_dm_req = $urandom_range(0, 2) != 0;
        i_dm_we = 1'($urandom_range(0, 1));
        i_dm_addr = 32'($urandom_range(0, 7)) << 2;
        i_dm_wdata = $urandom;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
